// File: rtl/risc_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : risc_regfile_arbiter
// Purpose  : Shares a 2R/1W register file between the CPU core and a debug
//            port. After reset it clears every register to INIT_VALUE while
//            stalling the core. The core always has priority. Debug reads
//            borrow the rs2 read port and debug writes borrow the rd write
//            port, but only in slots the core leaves idle.
// Ports    :
//   clk, rst_n                 clock (rising edge), async active-low reset
//   core_rs1_addr              passed straight to rf_rs1_addr
//   core_rs2_addr/core_rs2_en  core rs2 read address / port in use
//   core_rd_addr/_write/core_rd core write address, enable, data
//   core_stall                 core must hold (clear sequence running)
//   dbg_req_*                  debug request (valid/ready handshake)
//   dbg_rsp_*                  debug read response (valid/ready handshake)
//   rf_rs1_addr/rf_rs2_addr    register file read addresses
//   rf_rd_addr/_write/rf_rd    register file write port
//   rf_rs2                     register file rs2 data (registered, 1 cycle)
// Revision : 1.0 - initial release
// ============================================================================
module risc_regfile_arbiter #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 4,
  parameter bit                INIT_EN    = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] core_rs1_addr,
  input  logic [ADDR_W-1:0] core_rs2_addr,
  input  logic              core_rs2_en,
  input  logic [ADDR_W-1:0] core_rd_addr,
  input  logic              core_rd_write,
  input  logic [DATA_W-1:0] core_rd,
  output logic              core_stall,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_write,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic [ADDR_W-1:0] rf_rs1_addr,
  output logic [ADDR_W-1:0] rf_rs2_addr,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic              rf_rd_write,
  output logic [DATA_W-1:0] rf_rd,
  input  logic [DATA_W-1:0] rf_rs2
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RSP     = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;
  localparam state_e            ST_RESET = INIT_EN ? ST_INIT : ST_IDLE;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                fwd_q, fwd_d;
  logic [DATA_W-1:0]   fwd_data_q, fwd_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                rd_write_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fwd_d         = fwd_q;
    fwd_data_d    = fwd_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    core_stall    = 1'b0;
    dbg_req_ready = 1'b0;
    rf_rs2_addr   = core_rs2_addr;
    rf_rd_addr    = core_rd_addr;
    rd_write_mux  = core_rd_write;
    rf_rd         = core_rd;

    case (state_q)
      ST_INIT: begin
        // Core writes are ignored here; the write port belongs to the clear.
        core_stall   = 1'b1;
        rd_write_mux = 1'b1;
        rf_rd_addr   = cnt_q;
        rf_rd        = INIT_VALUE;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        // Debug only gets the port the core leaves unused this cycle.
        dbg_req_ready = dbg_req_write ? !core_rd_write : !core_rs2_en;
        if (dbg_req_valid && dbg_req_ready) begin
          if (dbg_req_write) begin
            rf_rd_addr   = dbg_req_addr;
            rd_write_mux = 1'b1;
            rf_rd        = dbg_req_wdata;
          end else begin
            rf_rs2_addr = dbg_req_addr;
            // The file reads before it writes, so a core write to the same
            // register on this edge would be missed; capture it instead.
            fwd_d       = core_rd_write && (core_rd_addr == dbg_req_addr);
            fwd_data_d  = core_rd;
            state_d     = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        rsp_rdata_d = fwd_q ? fwd_data_q : rf_rs2;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end

      ST_RSP: begin
        if (dbg_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The reset state is INIT, whose write strobe must not reach the file
  // while reset is still asserted.
  assign rf_rd_write   = rd_write_mux & rst_n;
  assign rf_rs1_addr   = core_rs1_addr;
  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_regfile_arbiter
// Purpose  : Self-checking bench for risc_regfile_arbiter with a behavioural
//            16x8 register file (registered, read-before-write rs2 port).
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_regfile_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] core_rs1_addr, core_rs2_addr, core_rd_addr;
  logic       core_rs2_en, core_rd_write;
  logic [7:0] core_rd;
  logic       core_stall;
  logic       dbg_req_valid, dbg_req_ready, dbg_req_write;
  logic [3:0] dbg_req_addr;
  logic [7:0] dbg_req_wdata;
  logic       dbg_rsp_valid, dbg_rsp_ready;
  logic [7:0] dbg_rsp_rdata;
  logic [3:0] rf_rs1_addr, rf_rs2_addr, rf_rd_addr;
  logic       rf_rd_write;
  logic [7:0] rf_rd, rf_rs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc_regfile_arbiter #(
    .DATA_W(8), .ADDR_W(4), .INIT_EN(1'b1), .INIT_VALUE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_rs1_addr(core_rs1_addr), .core_rs2_addr(core_rs2_addr),
    .core_rs2_en(core_rs2_en), .core_rd_addr(core_rd_addr),
    .core_rd_write(core_rd_write), .core_rd(core_rd),
    .core_stall(core_stall),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdata(dbg_rsp_rdata),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rd_addr(rf_rd_addr), .rf_rd_write(rf_rd_write), .rf_rd(rf_rd),
    .rf_rs2(rf_rs2)
  );

  // Register file model: registered rs2 output, read-before-write.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    rf_rs2 <= mem[rf_rs2_addr];
    if (rf_rd_write) mem[rf_rd_addr] <= rf_rd;
  end

  typedef struct {
    logic       rs2_en;
    logic       rd_wr;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       dv;
    logic       dw;
    logic [3:0] da;
    logic [7:0] dwd;
    logic       rspr;
    logic       e_ready;
    logic       e_rfw;
    logic [3:0] e_rfa;
    logic [7:0] e_rfd;
    logic [3:0] e_rs2a;
    logic       e_rv;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rs2_en, input logic rd_wr, input logic [3:0] rd_addr,
    input logic [7:0] rd_data, input logic dv, input logic dw,
    input logic [3:0] da, input logic [7:0] dwd, input logic rspr,
    input logic e_ready, input logic e_rfw, input logic [3:0] e_rfa,
    input logic [7:0] e_rfd, input logic [3:0] e_rs2a, input logic e_rv,
    input logic [7:0] e_rdata);
    vec_t v;
    v.rs2_en = rs2_en; v.rd_wr = rd_wr; v.rd_addr = rd_addr;
    v.rd_data = rd_data; v.dv = dv; v.dw = dw; v.da = da; v.dwd = dwd;
    v.rspr = rspr; v.e_ready = e_ready; v.e_rfw = e_rfw; v.e_rfa = e_rfa;
    v.e_rfd = e_rfd; v.e_rs2a = e_rs2a; v.e_rv = e_rv; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rs2_en, input logic rd_wr,
                       input logic [3:0] rd_addr, input logic [7:0] rd_data,
                       input logic dv, input logic dw, input logic [3:0] da,
                       input logic [7:0] dwd, input logic rspr);
    core_rs2_en   = rs2_en;
    core_rd_write = rd_wr;
    core_rd_addr  = rd_addr;
    core_rd       = rd_data;
    dbg_req_valid = dv;
    dbg_req_write = dw;
    dbg_req_addr  = da;
    dbg_req_wdata = dwd;
    dbg_rsp_ready = rspr;
  endtask

  // Runs the clear sequence from the current point (just after reset
  // release, mid-cycle) and checks all 16 writes.
  task automatic check_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, core_stall, 1'b1);
      chk({tag, "_rfw"}, rf_rd_write, 1'b1);
      chk({tag, "_rfa"}, rf_rd_addr, i[3:0]);
      chk({tag, "_rfd"}, rf_rd, 8'hA5);
      chk({tag, "_ready"}, dbg_req_ready, 1'b0);
      chk({tag, "_rv"}, dbg_rsp_valid, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_done_stall"}, core_stall, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    core_rs1_addr = 4'h2;
    core_rs2_addr = 4'hE;
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0);

    // rs2_en rd_wr rd_a rd_d  dv dw da dwd  rspr | rdy rfw rfa rfd  rs2a rv rdata
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,1,4'h3,8'h3C, 0, 1,1,4'h3,8'h3C, 4'hE,0,8'h00));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,4'h3,8'h00, 0, 1,0,4'h0,8'h00, 4'h3,0,8'h00));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0, 0,0,4'h0,8'h00, 4'hE,0,8'h00));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 1, 0,0,4'h0,8'h00, 4'hE,1,8'h3C));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0, 1,0,4'h0,8'h00, 4'hE,0,8'h3C));
    vecs.push_back(mk(0,1,4'h1,8'h11, 1,1,4'h5,8'h5A, 0, 0,1,4'h1,8'h11, 4'hE,0,8'h3C));
    vecs.push_back(mk(0,1,4'h2,8'h22, 1,1,4'h5,8'h5A, 0, 0,1,4'h2,8'h22, 4'hE,0,8'h3C));
    vecs.push_back(mk(0,1,4'h7,8'h11, 1,1,4'h5,8'h5A, 0, 0,1,4'h7,8'h11, 4'hE,0,8'h3C));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,1,4'h5,8'h5A, 0, 1,1,4'h5,8'h5A, 4'hE,0,8'h3C));
    vecs.push_back(mk(0,1,4'h7,8'h99, 1,0,4'h7,8'h00, 0, 1,1,4'h7,8'h99, 4'h7,0,8'h3C));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0, 0,0,4'h0,8'h00, 4'hE,0,8'h3C));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,4'h5,8'h00, 0, 0,0,4'h0,8'h00, 4'hE,1,8'h99));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 1, 0,0,4'h0,8'h00, 4'hE,1,8'h99));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,4'h5,8'h00, 0, 1,0,4'h0,8'h00, 4'h5,0,8'h99));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0, 0,0,4'h0,8'h00, 4'hE,0,8'h99));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 1, 0,0,4'h0,8'h00, 4'hE,1,8'h5A));
    vecs.push_back(mk(1,0,4'h0,8'h00, 1,0,4'h5,8'h00, 0, 0,0,4'h0,8'h00, 4'hE,0,8'h5A));
    vecs.push_back(mk(1,0,4'h0,8'h00, 1,1,4'h3,8'h77, 0, 1,1,4'h3,8'h77, 4'hE,0,8'h5A));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0, 1,0,4'h0,8'h00, 4'hE,0,8'h5A));

    // Reset state while rst_n is low.
    #3;
    chk("rst_rv", dbg_rsp_valid, 1'b0);
    chk("rst_rdata", dbg_rsp_rdata, 8'h00);
    chk("rst_rfw", rf_rd_write, 1'b0);
    chk("rst_stall", core_stall, 1'b1);
    @(posedge clk); @(posedge clk); #3;
    chk("rst_rfw_hold", rf_rd_write, 1'b0);
    // Core write and debug request during INIT must be ignored.
    drive(0, 1, 4'h9, 8'hEE, 1, 1, 4'h4, 8'h44, 0);
    rst_n = 1'b1;
    check_init("init");
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0);
    @(posedge clk); #1;

    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].rs2_en, vecs[r].rd_wr, vecs[r].rd_addr, vecs[r].rd_data,
            vecs[r].dv, vecs[r].dw, vecs[r].da, vecs[r].dwd, vecs[r].rspr);
      @(negedge clk);
      chk($sformatf("v%0d_stall", r), core_stall, 1'b0);
      chk($sformatf("v%0d_rs1a", r), rf_rs1_addr, 4'h2);
      chk($sformatf("v%0d_ready", r), dbg_req_ready, vecs[r].e_ready);
      chk($sformatf("v%0d_rfw", r), rf_rd_write, vecs[r].e_rfw);
      chk($sformatf("v%0d_rfa", r), rf_rd_addr, vecs[r].e_rfa);
      chk($sformatf("v%0d_rfd", r), rf_rd, vecs[r].e_rfd);
      chk($sformatf("v%0d_rs2a", r), rf_rs2_addr, vecs[r].e_rs2a);
      chk($sformatf("v%0d_rv", r), dbg_rsp_valid, vecs[r].e_rv);
      chk($sformatf("v%0d_rdata", r), dbg_rsp_rdata, vecs[r].e_rdata);
      @(posedge clk); #1;
    end

    // Reset while a debug read sits in RD_WAIT: the read is dropped.
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h3, 8'h00, 0);
    @(negedge clk);
    chk("rw_accept", dbg_req_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_rst_rv", dbg_rsp_valid, 1'b0);
    chk("rw_rst_rdata", dbg_rsp_rdata, 8'h00);
    chk("rw_rst_rfw", rf_rd_write, 1'b0);
    chk("rw_rst_stall", core_stall, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    chk("rw_rst_rv2", dbg_rsp_valid, 1'b0);
    #2 rst_n = 1'b1;
    check_init("reinit");
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rv", dbg_rsp_valid, 1'b0);
      @(posedge clk); #1;
    end

    // r3 held 8'h77 before the re-init; it must now read back 8'hA5.
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h3, 8'h00, 0);
    @(posedge clk); #1;
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0);
    begin : wait_rsp
      int n;
      n = 0;
      while (dbg_rsp_valid !== 1'b1 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk("final_wait_cycles", n, 1);
    end
    chk("final_rdata", dbg_rsp_rdata, 8'hA5);
    dbg_rsp_ready = 1'b1;
    @(posedge clk); #1;
    dbg_rsp_ready = 1'b0;
    chk("final_rv_drop", dbg_rsp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_regfile_arbiter.md
Name: risc_regfile_arbiter

Overview:
Sits between the CPU core, a debug port and the 16x8 register file (two read ports, one write port). Clears every register after reset. Multiplexes the file's ports between core and debug, with the core always winning. Debug requests share the rs2 read port and the rd write port in idle slots. The file's read data is registered (1-cycle latency) and is read-before-write on the same edge.

Parameters:
DATA_W, 8, register width
ADDR_W, 4, register address width (2**ADDR_W registers)
INIT_EN, 1, 1 = run the clear sequence after reset; 0 = go straight to IDLE
INIT_VALUE, 8'h00, value written to every register during the clear sequence

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
core_rs1_addr  in  ADDR_W  core rs1 address (passed through)
core_rs2_addr  in  ADDR_W  core rs2 address
core_rs2_en  in  1  core uses rs2 this cycle
core_rd_addr  in  ADDR_W  core write address
core_rd_write  in  1  core write enable
core_rd  in  DATA_W  core write data
core_stall  out  1  core must hold; high during INIT
dbg_req_valid  in  1  debug request valid
dbg_req_ready  out  1  debug request accepted when valid&ready
dbg_req_write  in  1  1 = write, 0 = read
dbg_req_addr  in  ADDR_W  debug register address
dbg_req_wdata  in  DATA_W  debug write data
dbg_rsp_valid  out  1  read response valid
dbg_rsp_ready  in  1  response consumed
dbg_rsp_rdata  out  DATA_W  read response data
rf_rs1_addr  out  ADDR_W  to regfile
rf_rs2_addr  out  ADDR_W  to regfile
rf_rd_addr  out  ADDR_W  to regfile
rf_rd_write  out  1  to regfile
rf_rd  out  DATA_W  to regfile
rf_rs2  in  DATA_W  regfile rs2 output (registered)

Behaviour:
- Reset (rst_n low, async): state=INIT if INIT_EN else IDLE; init counter=0; dbg_rsp_valid=0; dbg_rsp_rdata=0; rf_rd_write forced 0 while rst_n low. Any pending debug op is dropped.
- States: INIT, IDLE, RD_WAIT, RSP.
- rf_rs1_addr = core_rs1_addr in every state.
- INIT:
  - rf_rd_write=1, rf_rd_addr=cnt, rf_rd=INIT_VALUE.
  - cnt increments every cycle; after cnt=2**ADDR_W-1 is written, next state is IDLE. Exactly 16 write cycles.
  - core_stall=1, dbg_req_ready=0, core writes ignored.
- core_stall=0 in all other states.
- Default muxing outside INIT: rf_rs2_addr=core_rs2_addr, rf_rd_addr/rf_rd_write/rf_rd = core signals.
- dbg_req_ready (combinational) = state==IDLE && (dbg_req_write ? !core_rd_write : !core_rs2_en). Core priority is absolute; a debug request may wait indefinitely.
- Debug write accepted:
  - In the accept cycle rf_rd_addr=dbg_req_addr, rf_rd_write=1, rf_rd=dbg_req_wdata.
  - State stays IDLE; no response is generated.
- Debug read accepted (edge E0):
  - In the accept cycle rf_rs2_addr=dbg_req_addr.
  - Forwarding check in the accept cycle: core_rd_write && core_rd_addr==dbg_req_addr → latch core_rd as forward data and set fwd flag.
  - State → RD_WAIT.
  - At E1: dbg_rsp_rdata = fwd ? forward data : rf_rs2; dbg_rsp_valid=1; state → RSP.
  - Response therefore appears 2 edges after the accept-cycle edge and returns post-write data on a same-cycle core write.
- rf_rs2 in the RD_WAIT cycle belongs to debug. The core did not assert core_rs2_en in the accept cycle, so it does not consume it.
- Core reads and writes proceed normally in RD_WAIT and RSP. Only new debug requests are blocked.
- RSP:
  - dbg_rsp_valid and dbg_rsp_rdata are held stable until dbg_rsp_ready=1.
  - On that edge dbg_rsp_valid=0 and state → IDLE.
  - No new request is accepted in the handshake cycle; at most one debug op is outstanding.
- Core write in the debug-read accept cycle is still performed (no conflict: different ports).

Test Plan:
- Release reset, INIT_EN=1, INIT_VALUE=8'hA5 → core_stall high 16 cycles; rf_rd_write=1 with rf_rd_addr 0..15 and rf_rd=8'hA5; then core_stall=0 and IDLE.
- IDLE, core idle, debug write r3=8'h3C then debug read r3 → write seen on rf port in accept cycle; dbg_rsp_valid rises 2 edges after read accept with rdata=8'h3C.
- Debug write r5 while core_rd_write=1 for 3 cycles → dbg_req_ready=0 for those 3 cycles; write issued in the first cycle core_rd_write=0; core writes unaffected.
- Debug read r7 accepted in the same cycle core writes r7=8'h99 (old value 8'h11) → dbg_rsp_rdata=8'h99.
- Read response with dbg_rsp_ready low 5 cycles → rsp_valid and rdata stable for 5 cycles, dbg_req_ready=0; drops after the handshake edge; ready returns next cycle.
- rst_n pulsed low while in RD_WAIT → dbg_rsp_valid=0 immediately; INIT re-runs fully; no response ever emitted for the dropped read.
